if1_inst_queue: RTL and testbench

Second fetch stage (IF1): a small circular instruction queue between the ICache read port and the decode stage. It captures the fetched instruction together with its PC and the predicted-taken bit, and presents entries to ID in program order. It back-pressures IF0 through `in_ready` and drops all contents on an EX redirect.

---
 rtl/if1_inst_queue.sv | 160 ++++++++++++++++
 tb/tb_if1_inst_queue.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/if1_inst_queue.sv
// -----------------------------------------------------------------------------
// if1_inst_queue
//
// Second fetch stage (IF1). A small circular instruction queue between the
// ICache read port and the decode stage. Each entry holds the fetched
// instruction, its PC and the IF0 predicted-taken bit. Entries are presented
// to ID in program order. IF0 is back-pressured through in_ready, and an EX
// redirect (flush) drops every queued entry.
//
// Handshake semantics (both sides): a transfer happens on a rising edge when
// valid and ready are both high in the cycle before that edge. in_ready
// depends only on the registered count; it never looks at in_valid or
// out_ready. out_valid never depends on out_ready.
//
// Optional feature (compile-time macro IF1_IQ_BYPASS_EN):
//   defined   - empty-queue bypass. With count == 0 and in_valid & ~flush the
//               incoming instruction is shown on out_* in the same cycle. If ID
//               also takes it (out_ready) it is never written to the queue.
//   undefined - no combinational path from in_* to out_*; 1-cycle latency.
//
// Parameters:
//   DEPTH  queue entries, power of two, >= 2
//   WORD   PC / instruction width
//
// Ports:
//   clk        sole clock, rising edge
//   rst        asynchronous reset, active low
//   in_valid   ICache returned an instruction this cycle
//   in_pc      PC of the returned instruction
//   in_inst    instruction word
//   in_pred    IF0 predicted this instruction taken
//   in_ready   queue can accept (IF0 stalls its PC on ~in_ready)
//   flush      EX branch redirect; discard everything
//   out_valid  head entry valid for ID
//   out_pc     head PC (0 when empty)
//   out_inst   head instruction (0 when empty)
//   out_pred   head predicted-taken bit (0 when empty)
//   out_ready  ID consumes the head this cycle
//   dbg_count  current occupancy, for observation only
// -----------------------------------------------------------------------------
module if1_inst_queue #(
    parameter int DEPTH = 4,
    parameter int WORD  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [WORD-1:0]        in_pc,
    input  logic [WORD-1:0]        in_inst,
    input  logic                   in_pred,
    output logic                   in_ready,
    input  logic                   flush,
    output logic                   out_valid,
    output logic [WORD-1:0]        out_pc,
    output logic [WORD-1:0]        out_inst,
    output logic                   out_pred,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] dbg_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 2 * WORD + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    // Entry layout: {pc, inst, pred}
    typedef logic [EW-1:0] entry_t;

    entry_t          mem [DEPTH];
    logic [AW-1:0]   head;
    logic [AW-1:0]   tail;
    logic [CW-1:0]   count;

    logic            empty;
    logic            push;
    logic            wr_en;
    logic            pop;
    entry_t          head_entry;

    assign empty      = (count == '0);
    assign head_entry = mem[head];
    assign in_ready   = (count != FULL);
    assign dbg_count  = count;

    // A push is refused when full even if ID pops in the same cycle; this
    // keeps in_ready a pure function of registered state.
    assign push = in_valid & in_ready & ~flush;

`ifdef IF1_IQ_BYPASS_EN
    logic bypass;

    assign bypass = empty & in_valid & ~flush;

    always_comb begin
        out_valid = (~empty | bypass) & ~flush;
        out_pc    = '0;
        out_inst  = '0;
        out_pred  = 1'b0;
        if (bypass) begin
            out_pc   = in_pc;
            out_inst = in_inst;
            out_pred = in_pred;
        end else if (!empty) begin
            out_pc   = head_entry[EW-1 -: WORD];
            out_inst = head_entry[WORD:1];
            out_pred = head_entry[0];
        end
    end

    // A bypassed instruction taken by ID the same cycle never enters storage.
    assign wr_en = push & ~(bypass & out_ready);
`else
    always_comb begin
        out_valid = ~empty & ~flush;
        out_pc    = '0;
        out_inst  = '0;
        out_pred  = 1'b0;
        if (!empty) begin
            out_pc   = head_entry[EW-1 -: WORD];
            out_inst = head_entry[WORD:1];
            out_pred = head_entry[0];
        end
    end

    assign wr_en = push;
`endif

    // Only a stored entry advances head; a bypass hand-off leaves it alone.
    assign pop = out_valid & out_ready & ~empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            // Storage is left as is; pointers alone define what is valid.
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (wr_en) begin
                mem[tail] <= {in_pc, in_inst, in_pred};
                tail      <= tail + AW'(1);
            end
            if (pop) begin
                head <= head + AW'(1);
            end
            case ({wr_en, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_if1_inst_queue.sv
module tb_if1_inst_queue;

  localparam int DEPTH = 4;
  localparam int WORD  = 32;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int EW    = 2 * WORD + 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic [WORD-1:0] in_pc;
  logic [WORD-1:0] in_inst;
  logic            in_pred;
  logic            in_ready;
  logic            flush;
  logic            out_valid;
  logic [WORD-1:0] out_pc;
  logic [WORD-1:0] out_inst;
  logic            out_pred;
  logic            out_ready;
  logic [CW-1:0]   dbg_count;

  int checks   = 0;
  int failures = 0;

  // Scoreboard: entries {pc, inst, pred} the queue must still deliver.
  logic [EW-1:0] exp_q[$];
  logic          seen_dropped = 1'b0;
  logic [4:0]    pred_pat = 5'b01101;  // bit i gives 1,0,1,1,0

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  if1_inst_queue #(.DEPTH(DEPTH), .WORD(WORD)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_pc     (in_pc),
    .in_inst   (in_inst),
    .in_pred   (in_pred),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_valid (out_valid),
    .out_pc    (out_pc),
    .out_inst  (out_inst),
    .out_pred  (out_pred),
    .out_ready (out_ready),
    .dbg_count (dbg_count)
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_fields"}, {out_pc, out_inst, out_pred}, 0);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_count"}, dbg_count, 0);
  endtask

  // ---------------- driver ----------------
  // One clock cycle: drive after the falling edge, check outputs against the
  // scoreboard, update the scoreboard for the coming rising edge.
  task automatic cycle(input logic v, input logic [WORD-1:0] pc, input logic pred,
                       input logic ordy, input logic fl);
    logic          byp;
    logic          exp_valid;
    logic          do_push;
    logic [EW-1:0] exp_e;
    logic [WORD-1:0] inst;
    @(negedge clk);
    inst      = $urandom;
    in_valid  = v;
    in_pc     = pc;
    in_inst   = inst;
    in_pred   = pred;
    out_ready = ordy;
    flush     = fl;
    #1;
    byp = 1'b0;
`ifdef IF1_IQ_BYPASS_EN
    byp = (exp_q.size() == 0) && v && !fl;
`endif
    exp_valid = ((exp_q.size() != 0) || byp) && !fl;
    check("in_ready", in_ready, exp_q.size() != DEPTH);
    check("out_valid", out_valid, exp_valid);
    check("count", dbg_count, exp_q.size());
    if (exp_valid) begin
      exp_e = byp ? {pc, inst, pred} : exp_q[0];
      check("out_entry", {out_pc, out_inst, out_pred}, exp_e);
    end else if (exp_q.size() == 0) begin
      check("out_zero", {out_pc, out_inst, out_pred}, 0);
    end
    if (out_valid && out_pc == 32'h1c00_0040) seen_dropped = 1'b1;

    if (fl) begin
      exp_q.delete();
    end else if (!(byp && ordy)) begin
      do_push = v && (exp_q.size() != DEPTH);
      if (exp_valid && ordy) void'(exp_q.pop_front());
      if (do_push) exp_q.push_back({pc, inst, pred});
    end
    @(posedge clk);
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, '0, 1'b0, ordy, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_pc     = '0;
    in_inst   = '0;
    in_pred   = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    #1;
    check_reset_outputs("reset");
    #20;
    @(negedge clk);
    rst = 1'b1;

    // Streaming with ID always ready: count stays at 1 at most.
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 32'h1c00_0000 + 32'(4 * i), pred_pat[i], 1'b1, 1'b0);
    end
    idle(1'b1);
    idle(1'b1);

    // Fill with ID stalled: fifth push refused, then drain in order.
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 32'h1c00_0010 + 32'(4 * i), pred_pat[i], 1'b0, 1'b0);
    end
    for (int i = 0; i < 4; i++) idle(1'b1);
    idle(1'b1);

    // Wrap-around with count oscillating between 2 and 3.
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 32'h1c00_0080 + 32'(4 * i), pred_pat[i], 1'b0, 1'b0);
    end
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 32'h1c00_0088 + 32'(4 * i), pred_pat[(i + 2) % 5], 1'b0, 1'b0);
      idle(1'b1);
    end
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    // Flush with three entries queued and a simultaneous push.
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 32'h1c00_0030 + 32'(4 * i), pred_pat[i], 1'b0, 1'b0);
    end
    cycle(1'b1, 32'h1c00_0040, 1'b1, 1'b1, 1'b1);
    idle(1'b1);
    cycle(1'b1, 32'h1c00_0050, 1'b1, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Asynchronous reset mid-stream with two entries queued.
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 32'h1c00_00c0 + 32'(4 * i), pred_pat[i], 1'b0, 1'b0);
    end
    #2;
    rst      = 1'b0;
    in_valid = 1'b0;
    flush    = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    cycle(1'b1, 32'h1c00_0100, 1'b0, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Empty queue with ID ready: same-cycle hand-off when bypass is built in,
    // one-cycle latency otherwise; the scoreboard covers both builds.
    cycle(1'b1, 32'h1c00_0200, 1'b1, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);

    check("flushed_pc_never_seen", seen_dropped, 0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
